// File: rtl/psram_arbiter_if.sv
// psram_arbiter_if
//   Bundles the two client request ports, the shared read-data return and
//   the PSRAM controller strobe/data signals into one interface.
//   modport master : the arbiter (drives acks, rvalids, rdata, err, mem_* strobes)
//   modport slave  : the environment (clients and controller)
interface psram_arbiter_if #(
   parameter int ADDR_W = 22
);
   // client side
   logic              c0_req,    c1_req;
   logic              c0_we,     c1_we;
   logic [ADDR_W-1:0] c0_addr,   c1_addr;
   logic [15:0]       c0_wdata,  c1_wdata;
   logic              c0_byte_we, c1_byte_we;
   logic              c0_ack,    c1_ack;
   logic              c0_rvalid, c1_rvalid;
   logic [15:0]       rdata;
   logic              err;
   // controller side
   logic              mem_read,  mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_din;
   logic              mem_byte_write;
   logic [15:0]       mem_dout;
   logic              mem_busy;

   modport master (
      input  c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr,
             c0_wdata, c1_wdata, c0_byte_we, c1_byte_we,
             mem_dout, mem_busy,
      output c0_ack, c1_ack, c0_rvalid, c1_rvalid, rdata, err,
             mem_read, mem_write, mem_addr, mem_din, mem_byte_write
   );

   modport slave (
      output c0_req, c1_req, c0_we, c1_we, c0_addr, c1_addr,
             c0_wdata, c1_wdata, c0_byte_we, c1_byte_we,
             mem_dout, mem_busy,
      input  c0_ack, c1_ack, c0_rvalid, c1_rvalid, rdata, err,
             mem_read, mem_write, mem_addr, mem_din, mem_byte_write
   );
endinterface

// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Two-client round-robin arbiter in front of the PSRAM controller. Converts
//   req/ack client handshakes into single-cycle mem_read/mem_write strobes,
//   follows mem_busy through each transaction and routes read data back to
//   the issuing client. All outputs are registered.
// Ports:
//   clk    : system clock (shared with the controller)
//   resetn : asynchronous active-low reset
//   bus    : psram_arbiter_if.master (client ports, rdata/err, mem_* signals)
// Optional feature macro: PSRAM_ARB_TIMEOUT_EN
//   Defined   : per-phase watchdog of TIMEOUT_CYCLES; sets sticky err, returns
//               to IDLE and answers an abandoned read with 16'hDEAD.
//   Undefined : no watchdog, err tied low, waits indefinitely.
module psram_arbiter #(
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int ADDR_W         = 22
) (
   input  logic            clk,
   input  logic            resetn,
   psram_arbiter_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

   state_t            r_state, w_next;
   logic              r_ack0, r_ack1, r_rd, r_wr, r_rv0, r_rv1;
   logic [15:0]       r_rdata, r_din;
   logic [ADDR_W-1:0] r_addr;
   logic              r_bw, r_owner, r_we, r_last;

   logic              w_ack0_d, w_ack1_d, w_rd_d, w_wr_d, w_rv0_d, w_rv1_d;
   logic [15:0]       w_rdata_d, w_din_d;
   logic [ADDR_W-1:0] w_addr_d;
   logic              w_bw_d, w_owner_d, w_we_d, w_last_d;

   // r_last = 1 means client 1 was granted last, so client 0 wins a tie
   logic w_any, w_win1, w_grant, w_tmo;
   assign w_any   = bus.c0_req | bus.c1_req;
   assign w_win1  = bus.c1_req & (~bus.c0_req | ~r_last);
   assign w_grant = (r_state == IDLE) & ~bus.mem_busy & w_any;

`ifdef PSRAM_ARB_TIMEOUT_EN
   logic [15:0] r_cnt;
   logic        r_err;
   // only fires when the phase would not have exited normally this cycle
   assign w_tmo = (((r_state == WAIT_BUSY) & ~bus.mem_busy) |
                   ((r_state == WAIT_DONE) &  bus.mem_busy)) &
                  (r_cnt == 16'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)                                      r_cnt <= '0;
      else if (r_state == ISSUE)                        r_cnt <= '0;
      else if ((r_state == WAIT_BUSY) && bus.mem_busy)  r_cnt <= '0;
      else if ((r_state == WAIT_BUSY) || (r_state == WAIT_DONE))
                                                        r_cnt <= r_cnt + 16'd1;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)    r_err <= 1'b0;
      else if (w_tmo) r_err <= 1'b1;
   end
   assign bus.err = r_err;
`else
   assign w_tmo   = 1'b0;
   assign bus.err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_next;
   end

   // next state
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_grant) w_next = ISSUE;
         ISSUE:     w_next = WAIT_BUSY;
         WAIT_BUSY: if (bus.mem_busy) w_next = WAIT_DONE;
                    else if (w_tmo)   w_next = IDLE;
         WAIT_DONE: if (!bus.mem_busy) w_next = IDLE;
                    else if (w_tmo)    w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // outputs: next values of the registered outputs; pulses default low so
   // the strobe/ack raised at grant clears automatically in ISSUE
   always_comb begin
      w_ack0_d  = 1'b0;
      w_ack1_d  = 1'b0;
      w_rd_d    = 1'b0;
      w_wr_d    = 1'b0;
      w_rv0_d   = 1'b0;
      w_rv1_d   = 1'b0;
      w_rdata_d = r_rdata;
      w_addr_d  = r_addr;
      w_din_d   = r_din;
      w_bw_d    = r_bw;
      w_owner_d = r_owner;
      w_we_d    = r_we;
      w_last_d  = r_last;
      case (r_state)
         IDLE: if (w_grant) begin
            w_owner_d = w_win1;
            w_last_d  = w_win1;
            w_we_d    = w_win1 ? bus.c1_we      : bus.c0_we;
            w_addr_d  = w_win1 ? bus.c1_addr    : bus.c0_addr;
            w_din_d   = w_win1 ? bus.c1_wdata   : bus.c0_wdata;
            w_bw_d    = w_win1 ? bus.c1_byte_we : bus.c0_byte_we;
            w_rd_d    = ~w_we_d;
            w_wr_d    =  w_we_d;
            w_ack0_d  = ~w_win1;
            w_ack1_d  =  w_win1;
         end
         WAIT_DONE: if (!bus.mem_busy && !r_we) begin
            w_rdata_d = bus.mem_dout;
            w_rv0_d   = ~r_owner;
            w_rv1_d   =  r_owner;
         end
         default: ;
      endcase
      // an abandoned read still gets a (poisoned) response
      if (w_tmo && !r_we) begin
         w_rdata_d = 16'hDEAD;
         w_rv0_d   = ~r_owner;
         w_rv1_d   =  r_owner;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_ack0 <= 1'b0; r_ack1 <= 1'b0; r_rd <= 1'b0; r_wr <= 1'b0;
         r_rv0 <= 1'b0;  r_rv1 <= 1'b0;  r_rdata <= '0; r_addr <= '0;
         r_din <= '0;    r_bw <= 1'b0;   r_owner <= 1'b0; r_we <= 1'b0;
         r_last <= 1'b1;
      end else begin
         r_ack0 <= w_ack0_d; r_ack1 <= w_ack1_d; r_rd <= w_rd_d; r_wr <= w_wr_d;
         r_rv0 <= w_rv0_d;   r_rv1 <= w_rv1_d;   r_rdata <= w_rdata_d;
         r_addr <= w_addr_d; r_din <= w_din_d;   r_bw <= w_bw_d;
         r_owner <= w_owner_d; r_we <= w_we_d;   r_last <= w_last_d;
      end
   end

   assign bus.c0_ack         = r_ack0;
   assign bus.c1_ack         = r_ack1;
   assign bus.c0_rvalid      = r_rv0;
   assign bus.c1_rvalid      = r_rv1;
   assign bus.rdata          = r_rdata;
   assign bus.mem_read       = r_rd;
   assign bus.mem_write      = r_wr;
   assign bus.mem_addr       = r_addr;
   assign bus.mem_din        = r_din;
   assign bus.mem_byte_write = r_bw;

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Two-client round-robin arbiter placed directly upstream of the PSRAM controller.
- Turns independent client requests (req/ack handshake) into the controller's single-cycle read/write strobes.
- Tracks the controller busy flag across each transaction and returns read words to the client that issued the read.
- Lets a CPU-side port and a video/DMA port share the one on-chip HyperRAM die.

Parameters:
- TIMEOUT_CYCLES, 1024: watchdog limit per transaction phase; used only when PSRAM_ARB_TIMEOUT_EN is defined.
- ADDR_W, 22: byte address width, matching the controller address.

Ports:
- clk  in  1  system clock, same clock as the controller.
- resetn  in  1  asynchronous active-low reset.
- c0_req, c1_req  in  1 each  client request; held high with fields stable until ack.
- c0_we, c1_we  in  1 each  1 = write, 0 = read.
- c0_addr, c1_addr  in  ADDR_W each  byte address.
- c0_wdata, c1_wdata  in  16 each  write word.
- c0_byte_we, c1_byte_we  in  1 each  byte write; addr[0] selects the half.
- c0_ack, c1_ack  out  1 each  one-cycle pulse: request accepted.
- c0_rvalid, c1_rvalid  out  1 each  one-cycle pulse: read data valid.
- rdata  out  16  read word, shared by both clients, qualified by cN_rvalid.
- err  out  1  sticky timeout flag.
- mem_read, mem_write  out  1 each  strobes to the controller.
- mem_addr  out  ADDR_W  address to the controller.
- mem_din  out  16  write data to the controller.
- mem_byte_write  out  1  byte-write qualifier to the controller.
- mem_dout  in  16  controller read data.
- mem_busy  in  1  controller busy flag.

Behaviour:
- Reset (async, resetn=0):
  - All outputs 0; state IDLE; last_grant=1, so client 0 wins the first tie.
  - Any in-flight transaction is abandoned: no ack, no rvalid is emitted for it.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitration happens only when mem_busy=0 and at least one cN_req=1. mem_busy is high after reset until controller configuration completes; no request is accepted before then.
  - Single requester: it wins.
  - Both requesting: grant the client that is not last_grant, then set last_grant to the winner.
  - On grant:
    - Latch the winner's we/addr/wdata/byte_we into the mem_* registers.
    - Set mem_read=~we or mem_write=we.
    - Pulse cN_ack=1 for one cycle and record the owner.
    - Go to ISSUE.
- ISSUE (cycle after grant):
  - mem_read/mem_write and cN_ack are visible high in this cycle only; clear them at this cycle's edge.
  - Go to WAIT_BUSY.
  - mem_addr, mem_din and mem_byte_write hold their values until the next grant.
- WAIT_BUSY: go to WAIT_DONE when mem_busy=1. The controller raises busy the cycle after sampling the strobe.
- WAIT_DONE, when mem_busy=0:
  - Read: rdata<=mem_dout and pulse owner's cN_rvalid for one cycle.
  - Write: no response pulse.
  - Go to IDLE.
- Timing: back-to-back requests are spaced by at least the controller busy time plus 3 cycles.
- Latency: req sampled in cycle 0 → ack and strobe in cycle 1 → rvalid in the cycle after mem_busy falls.
- Client obligation: drop req, or present a new request, in the cycle after ack. The arbiter never samples req outside IDLE, so a held req is not double-counted during ISSUE.
- A request that arrives while the arbiter is not in IDLE, or while mem_busy=1, waits; it is never dropped.
- A client's rvalid never coincides with its own ack.

Optional Feature:
- Macro: PSRAM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on entry to WAIT_BUSY and on entry to WAIT_DONE, and increments every cycle in those states.
  - When it reaches TIMEOUT_CYCLES-1, set err=1 (sticky until reset) and go to IDLE.
  - For a read, also pulse owner's rvalid with rdata=16'hDEAD.
- Not defined: no counter; err is tied 0; the arbiter waits indefinitely.

Test Plan:
- Reset release, mem_busy high for 200 cycles while c0 requests a read → no ack until mem_busy is low; ack exactly 1 cycle after the first IDLE cycle with busy=0.
- c0 write addr=22'h000100, wdata=16'hA55A → mem_write high for exactly 1 cycle with mem_addr=22'h000100, mem_din=16'hA55A, mem_byte_write=0; no c0_rvalid.
- c1 read addr=22'h3FFFFE; bench model returns mem_dout=16'h1234 with 12 busy cycles → c1_rvalid pulses once with rdata=16'h1234; c0_rvalid stays 0.
- c0 and c1 both hold req continuously for 4 transactions → grants alternate c0, c1, c0, c1 starting with c0; no ack overlaps an active transaction.
- resetn pulsed low during WAIT_DONE of a c0 read → outputs are 0 immediately (asynchronous); no c0_rvalid after release; the next request is serviced normally.
- PSRAM_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16 and mem_busy never rising after the strobe → err=1 after 16 WAIT_BUSY cycles; c0_rvalid with rdata=16'hDEAD; state back in IDLE.
